// File: rtl/tff_toggle_monitor_if.sv
// Period-measurement output port of tff_toggle_monitor: one word per accepted
// valid/ready handshake. master = monitor side, slave = consumer side.
interface tff_toggle_monitor_if #(
  parameter int CNT_W = 8
);
  logic [CNT_W-1:0] per_data;
  logic             per_sat;
  logic             per_valid;
  logic             per_ready;

  modport master (
    output per_data,
    output per_sat,
    output per_valid,
    input  per_ready
  );

  modport slave (
    input  per_data,
    input  per_sat,
    input  per_valid,
    output per_ready
  );
endinterface

// File: rtl/tff_toggle_monitor.sv
// Edge counter and rising-to-rising period meter for the T flip-flop chain output.
// Define TFF_MON_SYNC_EN to pass q_in through a two-flop synchronizer (+2 cycles latency).
module tff_toggle_monitor #(
  parameter int CNT_W  = 8,
  parameter int EDGE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              q_in,
  input  logic              clr,
  output logic [EDGE_W-1:0] rise_cnt,
  output logic [EDGE_W-1:0] fall_cnt,
  output logic              per_ovf,
  tff_toggle_monitor_if.master per
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [EDGE_W-1:0] EDGE_ONE = EDGE_W'(1);

  logic             q_s;
  logic             q_d;
  logic             rise;
  logic             fall;
  logic             flush;
  logic             accept;
  logic [CNT_W-1:0] cnt;
  state_t           state;
  state_t           state_next;
  logic             cnt_load;
  logic             cnt_inc;
  logic             capture;

`ifdef TFF_MON_SYNC_EN
  logic [1:0] sync;

  // The synchronizer only follows rst; clr leaves the sampled stream untouched.
  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b00;
    else     sync <= {sync[0], q_in};
  end

  assign q_s = sync[1];
`else
  assign q_s = q_in;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk) begin
    if (rst) q_d <= 1'b0;
    else     q_d <= q_s;
  end

  assign rise   = q_s & ~q_d;
  assign fall   = ~q_s & q_d;
  assign flush  = rst | clr;
  assign accept = per.per_valid & per.per_ready;

  always_ff @(posedge clk) begin
    if (flush) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rise) state_next = MEASURE;
      MEASURE: state_next = MEASURE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: cnt_load = rise;
      MEASURE: begin
        cnt_load = rise;
        capture  = rise;
        cnt_inc  = ~rise;
      end
      default: ;
    endcase
  end

  // Period counter: the rise cycle itself counts as 1, so N samples between rises read N.
  always_ff @(posedge clk) begin
    if (flush)                           cnt <= '0;
    else if (cnt_load)                   cnt <= CNT_ONE;
    else if (cnt_inc && cnt != CNT_MAX)  cnt <= cnt + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      rise_cnt <= '0;
      fall_cnt <= '0;
    end else begin
      if (rise) rise_cnt <= rise_cnt + EDGE_ONE;
      if (fall) fall_cnt <= fall_cnt + EDGE_ONE;
    end
  end

  // Output word: a capture may replace the held word only when it is leaving
  // this cycle; otherwise the new measurement is dropped and flagged.
  always_ff @(posedge clk) begin
    if (flush) begin
      per.per_valid <= 1'b0;
      per.per_data  <= '0;
      per.per_sat   <= 1'b0;
      per_ovf       <= 1'b0;
    end else if (capture) begin
      if (!per.per_valid || per.per_ready) begin
        per.per_valid <= 1'b1;
        per.per_data  <= cnt;
        per.per_sat   <= (cnt == CNT_MAX);
      end else begin
        per_ovf <= 1'b1;
      end
    end else if (accept) begin
      per.per_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tff_toggle_monitor.sv
// Self-checking bench for tff_toggle_monitor (CNT_W=4, EDGE_W=4); scenario tasks
// plus a randomized run against a period/handshake reference model.
module tb_tff_toggle_monitor;

  localparam int CNT_W  = 4;
  localparam int EDGE_W = 4;
  localparam int SAT    = 15;
`ifdef TFF_MON_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              q_in = 1'b0;
  logic              clr = 1'b0;
  logic [EDGE_W-1:0] rise_cnt;
  logic [EDGE_W-1:0] fall_cnt;
  logic              per_ovf;

  tff_toggle_monitor_if #(.CNT_W(CNT_W)) pif ();

  tff_toggle_monitor #(.CNT_W(CNT_W), .EDGE_W(EDGE_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .q_in     (q_in),
    .clr      (clr),
    .rise_cnt (rise_cnt),
    .fall_cnt (fall_cnt),
    .per_ovf  (per_ovf),
    .per      (pif)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: edges counted as integers, periods as cycle-index differences.
  int m_rise, m_fall, m_last, m_cyc, m_data;
  bit m_prev, m_h1, m_h2, m_have, m_valid, m_sat, m_ovf;

  task automatic model_clear();
    m_rise = 0; m_fall = 0; m_have = 0;
    m_valid = 0; m_data = 0; m_sat = 0; m_ovf = 0;
  endtask

  task automatic model_step(input bit q, input bit c, input bit r, input bit rs);
    bit s, rz, fl, acc;
    int period;
`ifdef TFF_MON_SYNC_EN
    s = m_h2; m_h2 = m_h1; m_h1 = q;
`else
    s = q;
`endif
    m_cyc++;
    if (rs) begin
      m_h1 = 0; m_h2 = 0; m_prev = 0;
      model_clear();
      return;
    end
    rz = s & !m_prev;
    fl = !s & m_prev;
    m_prev = s;
    if (c) begin
      model_clear();
      return;
    end
    if (rz) m_rise++;
    if (fl) m_fall++;
    acc = m_valid & r;
    if (rz && m_have) begin
      period = m_cyc - m_last;
      if (!m_valid || r) begin
        m_valid = 1;
        m_data  = (period >= SAT) ? SAT : period;
        m_sat   = (period >= SAT);
      end else begin
        m_ovf = 1;
      end
    end else if (acc) begin
      m_valid = 0;
    end
    if (rz) begin
      m_last = m_cyc;
      m_have = 1;
    end
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge,
  // return at the next falling edge where outputs are sampled.
  task automatic tick(input bit q, input bit c, input bit r, input bit rs);
    q_in = q; clr = c; pif.per_ready = r; rst = rs;
    @(posedge clk);
    model_step(q, c, r, rs);
    @(negedge clk);
  endtask

  task automatic do_clr();
    for (int i = 0; i <= LAT; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (rise_cnt !== '0 || fall_cnt !== '0 || per_ovf !== 1'b0 ||
          pif.per_valid !== 1'b0 || pif.per_data !== '0 || pif.per_sat !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs: got rise=%0d fall=%0d ovf=%0b valid=%0b data=%0d sat=%0b expected all 0",
                 rise_cnt, fall_cnt, per_ovf, pif.per_valid, pif.per_data, pif.per_sat);
      end
    end
    for (int i = 0; i <= LAT; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (rise_cnt !== 4'd1) begin
      failures++;
      $display("FAIL reset_first_rise: got rise_cnt=%0d expected 1", rise_cnt);
    end
    checks++;
    if (pif.per_valid !== 1'b0 || fall_cnt !== 4'd0) begin
      failures++;
      $display("FAIL reset_first_valid: got valid=%0b fall=%0d expected 0 0", pif.per_valid, fall_cnt);
    end
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < LAT; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pif.per_valid !== 1'b1 || pif.per_data !== 4'd5) begin
      failures++;
      $display("FAIL reset_measure_state: got valid=%0b data=%0d expected 1 5", pif.per_valid, pif.per_data);
    end
  endtask

  // Four periods of 3 high / 2 low, plus a low tail covering synchronizer latency.
  task automatic run_square(input bit r, output int words, output int bad_words, output bit ovf_at_first);
    bit first = 1;
    words = 0; bad_words = 0; ovf_at_first = 0;
    for (int n = 0; n < 20 + LAT + 1; n++) begin
      tick((n < 20) && ((n % 5) < 3), 1'b0, r, 1'b0);
      if (pif.per_valid) begin
        words++;
        if (pif.per_data !== 4'd5 || pif.per_sat !== 1'b0) bad_words++;
        if (first) ovf_at_first = per_ovf;
        first = 0;
      end
    end
  endtask

  task automatic test_square();
    int words, bad;
    bit ovf0;
    do_clr();
    run_square(1'b1, words, bad, ovf0);
    checks++;
    if (words !== 3) begin
      failures++;
      $display("FAIL square_words: got %0d expected 3", words);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL square_values: got %0d words not 5/unsat expected 0", bad);
    end
    checks++;
    if (rise_cnt !== 4'd4 || fall_cnt !== 4'd4 || per_ovf !== 1'b0) begin
      failures++;
      $display("FAIL square_counts: got rise=%0d fall=%0d ovf=%0b expected 4 4 0", rise_cnt, fall_cnt, per_ovf);
    end
  endtask

  task automatic test_backpressure();
    int words, bad;
    bit ovf0;
    do_clr();
    run_square(1'b0, words, bad, ovf0);
    checks++;
    if (bad !== 0 || ovf0 !== 1'b0) begin
      failures++;
      $display("FAIL bp_held_word: got %0d unstable cycles ovf_at_first=%0b expected 0 0", bad, ovf0);
    end
    checks++;
    if (pif.per_valid !== 1'b1 || pif.per_data !== 4'd5 || per_ovf !== 1'b1) begin
      failures++;
      $display("FAIL bp_end: got valid=%0b data=%0d ovf=%0b expected 1 5 1", pif.per_valid, pif.per_data, per_ovf);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (pif.per_valid !== 1'b0 || per_ovf !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: got valid=%0b ovf=%0b expected 0 1", pif.per_valid, per_ovf);
    end
  endtask

  task automatic test_back_to_back();
    int pat[14] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0};
    do_clr();
    for (int i = 0; i < 14 + LAT; i++) begin
      tick((i < 14) ? pat[i][0] : 1'b0, 1'b0, (i == 9 + LAT), 1'b0);
      if (i == 8 + LAT) begin
        checks++;
        if (pif.per_valid !== 1'b1 || pif.per_data !== 4'd5) begin
          failures++;
          $display("FAIL b2b_first: got valid=%0b data=%0d expected 1 5", pif.per_valid, pif.per_data);
        end
      end
      if (i == 9 + LAT || i == 10 + LAT) begin
        checks++;
        if (pif.per_valid !== 1'b1 || pif.per_data !== 4'd4 || per_ovf !== 1'b0) begin
          failures++;
          $display("FAIL b2b_swap: got valid=%0b data=%0d ovf=%0b expected 1 4 0",
                   pif.per_valid, pif.per_data, per_ovf);
        end
      end
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (pif.per_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: got valid=%0b expected 0", pif.per_valid);
    end
  endtask

  task automatic test_saturation();
    int gaps[3] = '{14, 15, 20};
    int exp_data;
    bit exp_sat;
    foreach (gaps[k]) begin
      do_clr();
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i < gaps[k]; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < LAT; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
      exp_sat  = (gaps[k] >= SAT);
      exp_data = exp_sat ? SAT : gaps[k];
      checks++;
      if (pif.per_valid !== 1'b1 || pif.per_data !== CNT_W'(exp_data) || pif.per_sat !== exp_sat) begin
        failures++;
        $display("FAIL sat_gap%0d: got valid=%0b data=%0d sat=%0b expected 1 %0d %0b",
                 gaps[k], pif.per_valid, pif.per_data, pif.per_sat, exp_data, exp_sat);
      end
    end
  endtask

  task automatic test_wrap();
    do_clr();
    for (int i = 0; i < 17; i++) begin
      tick(1'b1, 1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
    end
    for (int i = 0; i < LAT; i++) tick(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (rise_cnt !== 4'd1 || fall_cnt !== 4'd1) begin
      failures++;
      $display("FAIL edge_wrap: got rise=%0d fall=%0d expected 1 1", rise_cnt, fall_cnt);
    end
  endtask

  task automatic test_clr_priority();
    int pat[18] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0};
    do_clr();
    for (int i = 0; i < 18; i++) begin
      tick(pat[i][0], (i == 9 + LAT), 1'b0, 1'b0);
      if (i == 8 + LAT) begin
        checks++;
        if (pif.per_valid !== 1'b1) begin
          failures++;
          $display("FAIL clr_setup: got valid=%0b expected 1", pif.per_valid);
        end
      end
      if (i == 9 + LAT) begin
        checks++;
        if (rise_cnt !== '0 || fall_cnt !== '0 || pif.per_valid !== 1'b0 ||
            pif.per_data !== '0 || pif.per_sat !== 1'b0 || per_ovf !== 1'b0) begin
          failures++;
          $display("FAIL clr_cleared: got rise=%0d fall=%0d valid=%0b data=%0d sat=%0b ovf=%0b expected all 0",
                   rise_cnt, fall_cnt, pif.per_valid, pif.per_data, pif.per_sat, per_ovf);
        end
      end
      if (i == 13 + LAT) begin
        checks++;
        if (rise_cnt !== 4'd1 || pif.per_valid !== 1'b0) begin
          failures++;
          $display("FAIL clr_idle_rise: got rise=%0d valid=%0b expected 1 0", rise_cnt, pif.per_valid);
        end
      end
    end
  endtask

  task automatic test_random();
    bit q = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(2) == 0) q = ~q;
      tick(q, ($urandom_range(63) == 0), $urandom_range(1) == 1, ($urandom_range(299) == 0));
      checks++;
      if (rise_cnt !== EDGE_W'(m_rise) || fall_cnt !== EDGE_W'(m_fall)) begin
        failures++;
        $display("FAIL rand_edges@%0d: got rise=%0d fall=%0d expected %0d %0d",
                 n, rise_cnt, fall_cnt, EDGE_W'(m_rise), EDGE_W'(m_fall));
      end
      checks++;
      if (pif.per_valid !== m_valid || per_ovf !== m_ovf) begin
        failures++;
        $display("FAIL rand_flags@%0d: got valid=%0b ovf=%0b expected %0b %0b",
                 n, pif.per_valid, per_ovf, m_valid, m_ovf);
      end
      checks++;
      if (pif.per_data !== CNT_W'(m_data) || pif.per_sat !== m_sat) begin
        failures++;
        $display("FAIL rand_word@%0d: got data=%0d sat=%0b expected %0d %0b",
                 n, pif.per_data, pif.per_sat, m_data, m_sat);
      end
    end
  endtask

  initial begin
    pif.per_ready = 1'b0;
    test_reset();
    test_square();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_wrap();
    test_clr_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
